// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared geometry defaults and FSM state encoding for the camera capture block
// Purpose: default frame geometry, write-address width and capture FSM state encoding,
//          imported by cam_capture_ctrl and cam_pixel_pack.
// Ports:   none (package).
package cam_pkg;

  localparam int H_ACTIVE_DEF = 640;  // pixels per line
  localparam int V_ACTIVE_DEF = 480;  // lines per frame
  localparam int ADDR_W_DEF   = 19;   // enough for 640*480-1

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_VSYNC = 3'd1,
    ST_WAIT_FRAME = 3'd2,
    ST_CAPTURE    = 3'd3,
    ST_DONE       = 3'd4
  } cap_state_t;

endpackage

// File: rtl/cam_pixel_pack.sv
// rtl/cam_pixel_pack.sv - RGB565 byte pairing, staging register and one-entry write holding register
// Purpose: pairs camera bytes (high byte first) into 16-bit pixels, stages each completed
//          pixel for one cycle, then presents it on a valid/ready write port held in a
//          single-entry register. A pixel arriving while the holder is still unaccepted
//          is dropped and reported through drop.
// Ports:
//   PCLK, reset        clock, asynchronous active-high reset
//   clear              resets the byte toggle (frame start, line end)
//   flush              discards staged and held pixels and the byte toggle
//   byte_en/byte_data  one byte consumed per cycle while byte_en is high
//   pix_keep/pix_addr  from the top: whether the completing pixel is written, and its address
//   pix_complete       combinational: the byte consumed this cycle completes a pixel
//   odd_byte           byte toggle (1 = high byte held, waiting for low byte)
//   pending            a pixel is staged or held
//   drop               one-cycle pulse: completed pixel discarded because holder was busy
//   wr_valid/wr_ready/wr_addr/wr_data  frame-buffer write port
module cam_pixel_pack
  import cam_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              PCLK,
  input  logic              reset,
  input  logic              clear,
  input  logic              flush,
  input  logic              byte_en,
  input  logic [7:0]        byte_data,
  input  logic              pix_keep,
  input  logic [ADDR_W-1:0] pix_addr,
  output logic              pix_complete,
  output logic              odd_byte,
  output logic              pending,
  output logic              drop,
  input  logic              wr_ready,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data
);

  logic [7:0]        byte0;
  logic              stg_valid;
  logic [15:0]       stg_data;
  logic [ADDR_W-1:0] stg_addr;

  assign pix_complete = byte_en & odd_byte;
  assign pending      = stg_valid | wr_valid;

  always_ff @(posedge PCLK or posedge reset) begin
    if (reset) begin
      byte0     <= '0;
      odd_byte  <= 1'b0;
      stg_valid <= 1'b0;
      stg_data  <= '0;
      stg_addr  <= '0;
      drop      <= 1'b0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      drop <= 1'b0;
      if (flush) begin
        odd_byte  <= 1'b0;
        stg_valid <= 1'b0;
        wr_valid  <= 1'b0;
      end else begin
        // Pairing stage: even byte is held, odd byte completes a pixel into the staging reg.
        stg_valid <= 1'b0;
        if (clear) begin
          odd_byte <= 1'b0;
        end else if (byte_en) begin
          if (!odd_byte) begin
            byte0    <= byte_data;
            odd_byte <= 1'b1;
          end else begin
            odd_byte  <= 1'b0;
            stg_valid <= pix_keep;
            stg_data  <= {byte0, byte_data};
            stg_addr  <= pix_addr;
          end
        end
        // Holding stage: a new pixel may replace one being accepted this same cycle.
        if (stg_valid) begin
          if (wr_valid && !wr_ready) begin
            drop <= 1'b1;
          end else begin
            wr_valid <= 1'b1;
            wr_addr  <= stg_addr;
            wr_data  <= stg_data;
          end
        end else if (wr_valid && wr_ready) begin
          wr_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/cam_capture_ctrl.sv
// rtl/cam_capture_ctrl.sv - camera frame capture controller: sync tracking, geometry counters, write addressing
// Purpose: waits for a start request and a full VSYNC pulse, then captures one RGB565 frame
//          from a DVP-style camera into a frame buffer at address line*H_ACTIVE+column.
//          Reports dropped pixels (overflow) and line/frame geometry errors (length_err).
// Optional feature: define CAM_CAPTURE_FRAME_COUNT_EN to add a 16-bit wrapping frame_count output.
// Ports:
//   PCLK, reset                 clock, asynchronous active-high reset
//   VSYNC, HREF, DATA           camera sync and byte stream (registered before use)
//   start, continuous, abort    capture control
//   wr_valid/wr_ready/wr_addr/wr_data  frame-buffer pixel write port
//   busy                        high in any state except IDLE
//   frame_done                  one-cycle pulse at frame end
//   overflow, length_err        sticky error flags, cleared on reset or accepted start
//   frame_count                 (optional) frames completed
module cam_capture_ctrl
  import cam_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic              PCLK,
  input  logic              reset,
  input  logic              VSYNC,
  input  logic              HREF,
  input  logic [7:0]        DATA,
  input  logic              start,
  input  logic              continuous,
  input  logic              abort,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow,
  output logic              length_err
`ifdef CAM_CAPTURE_FRAME_COUNT_EN
  ,
  output logic [15:0]       frame_count
`endif
);

  localparam int COL_W  = $clog2(H_ACTIVE + 1);
  localparam int LINE_W = $clog2(V_ACTIVE + 1);
  localparam logic [COL_W-1:0]  H_CNT  = COL_W'(H_ACTIVE);
  localparam logic [LINE_W-1:0] V_CNT  = LINE_W'(V_ACTIVE);
  localparam logic [LINE_W-1:0] V_LAST = LINE_W'(V_ACTIVE - 1);
  localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_ACTIVE);

  cap_state_t        state;
  logic              vsync_q, vsync_d, href_q, href_d;
  logic [7:0]        data_q;
  logic [COL_W-1:0]  col_cnt;    // saturates at H_ACTIVE so long lines cannot wrap
  logic [LINE_W-1:0] line_cnt;
  logic [ADDR_W-1:0] line_base;  // line_cnt*H_ACTIVE, held below H_ACTIVE*V_ACTIVE
  logic              end_req;    // early VSYNC seen: stop consuming, finish pending write

  logic vsync_rise, vsync_fall, href_fall, capturing, byte_en, pix_keep;
  logic clear_toggle, flush;
  logic pk_complete, pk_odd, pk_pending, pk_drop;
  logic [ADDR_W-1:0] pix_addr;

  // Camera inputs are registered once; all edges are taken on the registered copies.
  always_ff @(posedge PCLK or posedge reset) begin
    if (reset) begin
      vsync_q <= 1'b0;
      vsync_d <= 1'b0;
      href_q  <= 1'b0;
      href_d  <= 1'b0;
      data_q  <= '0;
    end else begin
      vsync_q <= VSYNC;
      vsync_d <= vsync_q;
      href_q  <= HREF;
      href_d  <= href_q;
      data_q  <= DATA;
    end
  end

  assign vsync_rise   = vsync_q & ~vsync_d;
  assign vsync_fall   = ~vsync_q & vsync_d;
  assign href_fall    = ~href_q & href_d;
  assign capturing    = (state == ST_CAPTURE) && !end_req && (line_cnt < V_CNT);
  assign byte_en      = capturing && href_q;
  assign pix_keep     = (col_cnt < H_CNT);
  assign pix_addr     = line_base + ADDR_W'(col_cnt);
  assign clear_toggle = ((state == ST_WAIT_FRAME) && vsync_fall) || (capturing && href_fall);
  assign flush        = abort && (state != ST_IDLE);
  assign busy         = (state != ST_IDLE);

  cam_pixel_pack #(.ADDR_W(ADDR_W)) u_pack (
    .PCLK         (PCLK),
    .reset        (reset),
    .clear        (clear_toggle),
    .flush        (flush),
    .byte_en      (byte_en),
    .byte_data    (data_q),
    .pix_keep     (pix_keep),
    .pix_addr     (pix_addr),
    .pix_complete (pk_complete),
    .odd_byte     (pk_odd),
    .pending      (pk_pending),
    .drop         (pk_drop),
    .wr_ready     (wr_ready),
    .wr_valid     (wr_valid),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data)
  );

  always_ff @(posedge PCLK or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      col_cnt    <= '0;
      line_cnt   <= '0;
      line_base  <= '0;
      end_req    <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      length_err <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (pk_drop) overflow <= 1'b1;

      if (flush) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state      <= ST_WAIT_VSYNC;
              overflow   <= 1'b0;
              length_err <= 1'b0;
            end
          end
          ST_WAIT_VSYNC: begin
            if (vsync_q) state <= ST_WAIT_FRAME;
          end
          ST_WAIT_FRAME: begin
            if (vsync_fall) begin
              state     <= ST_CAPTURE;
              col_cnt   <= '0;
              line_cnt  <= '0;
              line_base <= '0;
              end_req   <= 1'b0;
            end
          end
          ST_CAPTURE: begin
            if (pk_complete) begin
              if (col_cnt != H_CNT) col_cnt <= col_cnt + 1'b1;
              if (!pix_keep) length_err <= 1'b1;
            end
            if (capturing && href_fall) begin
              if (pk_odd || (col_cnt < H_CNT)) length_err <= 1'b1;
              line_cnt <= line_cnt + 1'b1;
              col_cnt  <= '0;
              if (line_cnt < V_LAST) line_base <= line_base + H_STEP;
            end
            if (vsync_rise && (line_cnt < V_CNT)) begin
              end_req    <= 1'b1;
              length_err <= 1'b1;
            end
            if (((line_cnt == V_CNT) || end_req) && !pk_pending) state <= ST_DONE;
          end
          ST_DONE: begin
            frame_done <= 1'b1;
            state      <= continuous ? ST_WAIT_VSYNC : ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef CAM_CAPTURE_FRAME_COUNT_EN
  always_ff @(posedge PCLK or posedge reset) begin
    if (reset) frame_count <= '0;
    else if (frame_done) frame_count <= frame_count + 16'd1;
  end
`endif

endmodule

// File: doc/cam_capture_ctrl.md
CAM_CAPTURE_CTRL -- requirements
Module: cam_capture_ctrl

Interface
REQ-001 SHALL have parameters: H_ACTIVE, 640, pixels per line; V_ACTIVE, 480, lines per frame; ADDR_W, 19, write-address width.
REQ-002 PCLK  input  1  sole clock; all logic on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 VSYNC  input  1  camera frame sync, high during vertical blanking pulse.
REQ-005 HREF  input  1  camera line valid.
REQ-006 DATA  input  8  camera byte stream, RGB565, high byte first.
REQ-007 start  input  1  single-cycle capture request.
REQ-008 continuous  input  1  re-arm automatically after each frame; sampled in DONE.
REQ-009 abort  input  1  single-cycle request to stop capture.
REQ-010 wr_valid  output  1  pixel write request.
REQ-011 wr_ready  input  1  frame-buffer accepts pixel.
REQ-012 wr_addr  output  ADDR_W  pixel address, line*H_ACTIVE+column.
REQ-013 wr_data  output  16  pixel {byte0,byte1}.
REQ-014 busy  output  1  high in any state except IDLE.
REQ-015 frame_done  output  1  one-cycle pulse at frame end.
REQ-016 overflow  output  1  sticky: pixel dropped because previous write not accepted.
REQ-017 length_err  output  1  sticky: line or frame geometry mismatch.

Function
REQ-018 SHALL register VSYNC, HREF, DATA once on PCLK before any use; edges are detected on the registered copies.
REQ-019 SHALL implement states IDLE, WAIT_VSYNC, WAIT_FRAME, CAPTURE, DONE.
REQ-020 IDLE->WAIT_VSYNC on start; start in any other state ignored.
REQ-021 WAIT_VSYNC->WAIT_FRAME when registered VSYNC high; WAIT_FRAME->CAPTURE on registered VSYNC falling edge, clearing line, column and address counters and the byte toggle.
REQ-022 In CAPTURE, each registered-HREF-high cycle SHALL consume one byte; even byte held, odd byte completes a pixel.
REQ-023 Completed pixel SHALL present wr_valid exactly 2 PCLK cycles after the edge at which its second byte was on DATA; wr_addr/wr_data stable while wr_valid && !wr_ready.
REQ-024 wr_valid SHALL drop the cycle after wr_valid && wr_ready unless a new pixel is loaded that same cycle.
REQ-025 Pixel completing while a previous pixel is still unaccepted SHALL be dropped, set overflow, address still advances.
REQ-026 Pixels beyond column H_ACTIVE-1 SHALL not be written and SHALL set length_err.
REQ-027 HREF falling edge SHALL increment line count and reset column and byte toggle; odd byte count or fewer than H_ACTIVE pixels sets length_err.
REQ-028 When line count reaches V_ACTIVE and no write pending -> DONE.
REQ-029 Registered VSYNC rising in CAPTURE before V_ACTIVE lines SHALL set length_err and go to DONE after any pending write completes.
REQ-030 DONE SHALL pulse frame_done one cycle, then go to WAIT_VSYNC if continuous else IDLE.
REQ-031 abort in any non-IDLE state SHALL clear wr_valid next cycle (pending pixel discarded), go IDLE, no frame_done.
REQ-032 Address arithmetic SHALL be ADDR_W bits, never exceeding H_ACTIVE*V_ACTIVE-1.
REQ-033 overflow and length_err SHALL clear only on reset or on start accepted in IDLE.

Reset
REQ-034 reset SHALL force state IDLE, all counters 0, wr_valid/busy/frame_done/overflow/length_err 0, wr_addr 0, wr_data 0, regardless of PCLK; mid-frame reset requires a fresh start and a full VSYNC pulse before capture.

Configuration
REQ-035 With CAM_CAPTURE_FRAME_COUNT_EN defined, SHALL add output frame_count (16 bits, reset 0) incrementing on each frame_done, wrapping 0xFFFF->0; without it, port and counter SHALL not exist.

Structure
REQ-036 H_ACTIVE/V_ACTIVE defaults, ADDR_W and state encodings SHALL live in shared package cam_pkg.
REQ-037 Byte pairing and one-entry write holding register SHALL be sub-module cam_pixel_pack; FSM and counters stay in top.

Verification
REQ-038 start, then full 640x480 frame from camera model, wr_ready=1 -> 307200 writes, addresses 0..307199 in order, frame_done once, no errors.
REQ-039 Bytes 0xF8,0x1F at line 0 col 0 -> wr_addr=0, wr_data=0xF81F, wr_valid 2 cycles after 0x1F on DATA.
REQ-040 wr_ready held low for 4 cycles mid-line -> overflow=1, dropped pixel addresses skipped, later addresses still line*640+col.
REQ-041 Line with 639 pixels, or VSYNC at line 300 -> length_err=1, frame_done pulsed, next frame's line 0 at address 0.
REQ-042 continuous=1 over 2 frames with CAM_CAPTURE_FRAME_COUNT_EN -> frame_count=2, busy never drops.
REQ-043 abort at line 100 and reset at line 200 (separate runs) -> wr_valid low next cycle, state IDLE, no frame_done.
